cpu_controller: RTL
===================

Name: cpu_controller

Overview:
Moore finite-state controller for the simple RISC datapath. It sits directly downstream of idecoder: it consumes opcode and ALU_op and drives back reg_sel, which selects the register field idecoder presents on r_addr/w_addr. It sequences the datapath load-enables, operand selects and register-file writes for one instruction per start request. The instruction register stays stable for the whole instruction.

Parameters:
WB_C, 2'b00, wb_sel code selecting datapath result C for write-back
WB_IMM8, 2'b10, wb_sel code selecting sximm8 for write-back

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level request to execute the instruction held in ir
opcode  input  3  from idecoder, ir[15:13]
ALU_op  input  2  from idecoder, ir[12:11]
waiting  output  1  high only in WAIT
reg_sel  output  2  to idecoder: 00=Rm, 01=Rd, 10=Rn
wb_sel  output  2  register-file write-data select (WB_C / WB_IMM8)
w_en  output  1  register-file write enable
en_A  output  1  load A register
en_B  output  1  load B register
en_C  output  1  load C register
en_status  output  1  load status flags
sel_A  output  1  1 = feed zero to ALU A input instead of A
sel_B  output  1  1 = feed sximm5 to ALU B input instead of shifted B

Behaviour:
- Registered state; all outputs are pure decodes of the current state (Moore). No combinational path from inputs to outputs.
- rst_n low, asynchronously: state=WAIT. waiting=1; all other outputs 0; reg_sel=00; wb_sel=WB_C.
- Reset mid-instruction aborts it immediately. A write already committed on an earlier edge stands; no further enables are asserted.
- States and Moore outputs. Any output not listed is 0; reg_sel defaults to 00 and wb_sel defaults to WB_C.
  - WAIT: waiting=1.
  - DECODE: no enables.
  - GET_A: reg_sel=Rn, en_A=1.
  - GET_B: reg_sel=Rm, en_B=1.
  - CALC: en_C=1, except for CMP, where en_status=1 and en_C=0. sel_A=1 when the instruction is MOV-reg or MVN.
  - WRITE_REG: reg_sel=Rd, wb_sel=WB_C, w_en=1.
  - WRITE_IMM: reg_sel=Rn, wb_sel=WB_IMM8, w_en=1.
- The instruction class is latched into a small class register on the DECODE->next edge. CALC/WRITE outputs decode from this register, not from the live inputs.
- Transitions:
  - WAIT: start=1 -> DECODE; otherwise stay in WAIT.
  - DECODE, by opcode/ALU_op:
    - 110/10 (MOV Rn,#imm8) -> WRITE_IMM
    - 110/00 (MOV Rd,Rm) -> GET_B
    - 101/11 (MVN) -> GET_B
    - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A
    - any other code is illegal -> WAIT, with no enables and no write.
  - GET_A -> GET_B.
  - GET_B -> CALC.
  - CALC: CMP -> WAIT; all others -> WRITE_REG.
  - WRITE_REG -> WAIT.
  - WRITE_IMM -> WAIT.
- Latency, counted as rising edges from the first edge sampling start=1 in WAIT to the edge re-entering WAIT:
  - MOV imm: 3
  - MOV reg / MVN: 5
  - ADD / AND: 6
  - CMP: 5
  - illegal: 2
- start is level-sensitive and is sampled only in WAIT. If start is still high on return to WAIT, the next instruction begins on the following edge, so waiting pulses for exactly one cycle.
- start is ignored outside WAIT.
- sel_B is always 0 in this instruction set. It is reserved for immediate ALU forms and is held 0.
- w_en and en_status are never high in the same cycle. At most one register-file write occurs per instruction.

Test Plan:
- Reset: hold rst_n=0 with no clock edges -> waiting=1, every other output 0. Release with start=0 for 5 cycles -> stays in WAIT, no enables.
- MOV imm: opcode=110, ALU_op=10, start pulse -> DECODE, then WRITE_IMM with reg_sel=10, wb_sel=10, w_en=1 for exactly one cycle -> waiting=1 on the 3rd edge.
- ADD: opcode=101, ALU_op=00 -> en_A with reg_sel=10, then en_B with reg_sel=00, then en_C with sel_A=0, then w_en with reg_sel=01, wb_sel=00 -> waiting on the 6th edge.
- CMP and MVN:
  - CMP (101/01) -> CALC asserts en_status=1, en_C=0; w_en never asserted; WAIT after 5 edges.
  - MVN (101/11) -> GET_B, then CALC with sel_A=1, then WRITE_REG.
- Illegal and back-to-back:
  - opcode=000 -> DECODE then WAIT, with every enable 0 throughout.
  - start held high across two MOV imm instructions -> waiting high for exactly 1 cycle between them.
- Mid-instruction reset: drop rst_n during GET_B of an ADD -> outputs go to reset values immediately, with no clock edge. Release with start=0 -> no w_en follows.

Source files
------------

// File: rtl/cpu_controller.sv
// Moore sequencer for the simple RISC datapath: one instruction per start request,
// all outputs decoded from the registered state and the latched instruction class.
module cpu_controller #(
    parameter logic [1:0] WB_C    = 2'b00,
    parameter logic [1:0] WB_IMM8 = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [1:0] ALU_op,
    output logic       waiting,
    output logic [1:0] reg_sel,
    output logic [1:0] wb_sel,
    output logic       w_en,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       sel_A,
    output logic       sel_B
);

    localparam logic [1:0] SEL_RM = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_RN = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_MOVI,
        CL_MOV,
        CL_MVN,
        CL_ADD,
        CL_CMP,
        CL_AND
    } class_t;

    state_t state, state_nx;
    class_t cls, dec_cls;

    always_comb begin
        dec_cls = CL_NONE;
        unique case ({opcode, ALU_op})
            5'b110_10: dec_cls = CL_MOVI;
            5'b110_00: dec_cls = CL_MOV;
            5'b101_11: dec_cls = CL_MVN;
            5'b101_00: dec_cls = CL_ADD;
            5'b101_01: dec_cls = CL_CMP;
            5'b101_10: dec_cls = CL_AND;
            default:   dec_cls = CL_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            cls   <= CL_NONE;
        end else begin
            state <= state_nx;
            // Class is captured once so later states never see a changing ir.
            if (state == S_DECODE)
                cls <= dec_cls;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT:      state_nx = start ? S_DECODE : S_WAIT;
            S_DECODE: begin
                unique case (dec_cls)
                    CL_MOVI:               state_nx = S_WRITE_IMM;
                    CL_MOV, CL_MVN:        state_nx = S_GET_B;
                    CL_ADD, CL_CMP, CL_AND: state_nx = S_GET_A;
                    default:               state_nx = S_WAIT;
                endcase
            end
            S_GET_A:     state_nx = S_GET_B;
            S_GET_B:     state_nx = S_CALC;
            S_CALC:      state_nx = (cls == CL_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nx = S_WAIT;
            S_WRITE_IMM: state_nx = S_WAIT;
            default:     state_nx = S_WAIT;
        endcase
    end

    always_comb begin
        waiting   = 1'b0;
        reg_sel   = SEL_RM;
        wb_sel    = WB_C;
        w_en      = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        unique case (state)
            S_WAIT:   waiting = 1'b1;
            S_DECODE: ;
            S_GET_A: begin
                reg_sel = SEL_RN;
                en_A    = 1'b1;
            end
            S_GET_B: begin
                reg_sel = SEL_RM;
                en_B    = 1'b1;
            end
            S_CALC: begin
                if (cls == CL_CMP)
                    en_status = 1'b1;
                else
                    en_C = 1'b1;
                sel_A = (cls == CL_MOV) || (cls == CL_MVN);
            end
            S_WRITE_REG: begin
                reg_sel = SEL_RD;
                wb_sel  = WB_C;
                w_en    = 1'b1;
            end
            S_WRITE_IMM: begin
                reg_sel = SEL_RN;
                wb_sel  = WB_IMM8;
                w_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
